// File: rtl/wb_bus_intercon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_intercon_pkg
// Description : Shared constants and state type for the Wishbone interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_bus_intercon_pkg;

    localparam int NSLAVE  = 16;
    localparam int LANE_W  = 32;
    localparam int SEL_W   = 4;

    localparam int RAM     = 0;
    localparam int DISK    = 1;
    localparam int VRAM    = 2;
    localparam int KBD     = 3;
    localparam int CNT     = 4;
    localparam int ERR_BIT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_bus_intercon_lane_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_lane_mux
// Description : Selects one 32-bit read lane out of the packed slave data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_lane_mux
    import wb_bus_intercon_pkg::*;
(
    input  logic [NSLAVE*LANE_W-1:0] lanes,
    input  logic [SEL_W-1:0]         sel,
    output logic [LANE_W-1:0]        dat
);

    logic [LANE_W-1:0] w_lane [NSLAVE];

    genvar gi;
    generate
        for (gi = 0; gi < NSLAVE; gi++) begin : g_lane
            assign w_lane[gi] = lanes[gi*LANE_W +: LANE_W];
        end
    endgenerate

    assign dat = w_lane[sel];

endmodule
`default_nettype wire

// File: rtl/wb_bus_intercon.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_intercon
// Description : Registered single-master, 16-slave Wishbone-style interconnect
//               with a bus watchdog that completes stuck cycles with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bus_intercon
    import wb_bus_intercon_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          master_STB,
    input  logic          master_WE,
    input  logic [31:0]   master_ADDR,
    input  logic [31:0]   master_DAT_I,
    output logic [31:0]   master_DAT_O,
    output logic          master_ACK,
    output logic [16:0]   slave_STB,
    input  logic [16:0]   slave_ACK,
    output logic          slave_WE,
    input  logic [511:0]  slave_DAT_I,
    output logic [31:0]   slave_DAT_O,
    output logic [31:0]   slave_ADDR
);

    localparam int             CNT_W       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t             r_state,  w_state;
    logic [CNT_W-1:0]   r_cnt,    w_cnt;
    logic [16:0]        r_stb,    w_stb;
    logic               r_ack,    w_ack;
    logic [31:0]        r_dat_o,  w_dat_o;
    logic [31:0]        r_addr,   w_addr;
    logic               r_we,     w_we;
    logic [31:0]        r_wdat,   w_wdat;

    logic [SEL_W-1:0]   w_sel;
    logic [LANE_W-1:0]  w_lane_dat;
    logic               w_sel_ack;

    // The lane is chosen from the latched address so late master changes are ignored.
    assign w_sel     = r_addr[31:28];
    assign w_sel_ack = slave_ACK[w_sel];

    wb_lane_mux u_lane_mux (
        .lanes (slave_DAT_I),
        .sel   (w_sel),
        .dat   (w_lane_dat)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_stb   <= '0;
            r_ack   <= 1'b0;
            r_dat_o <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdat  <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_stb   <= w_stb;
            r_ack   <= w_ack;
            r_dat_o <= w_dat_o;
            r_addr  <= w_addr;
            r_we    <= w_we;
            r_wdat  <= w_wdat;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_stb   = r_stb;
        w_ack   = r_ack;
        w_dat_o = r_dat_o;
        w_addr  = r_addr;
        w_we    = r_we;
        w_wdat  = r_wdat;

        case (r_state)
            IDLE: begin
                w_ack = 1'b0;
                w_stb = '0;
                if (master_STB) begin
                    w_addr                     = master_ADDR;
                    w_we                       = master_WE;
                    w_wdat                     = master_DAT_I;
                    w_stb[master_ADDR[31:28]]  = 1'b1;
                    w_cnt                      = '0;
                    w_state                    = BUSY;
                end
            end
            BUSY: begin
                // Abort wins over a same-cycle ACK: the master has already walked away.
                if (!master_STB) begin
                    w_stb   = '0;
                    w_state = IDLE;
                end else if (w_sel_ack) begin
                    w_stb   = '0;
                    w_ack   = 1'b1;
                    w_state = DONE;
                    if (!r_we) begin
                        w_dat_o = w_lane_dat;
                    end
                end else if (r_cnt == TIMEOUT_CNT) begin
                    w_stb          = '0;
                    w_stb[ERR_BIT] = 1'b1;
                    w_ack          = 1'b1;
                    w_state        = DONE;
                    if (!r_we) begin
                        w_dat_o = ERR_DATA;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                w_stb = '0;
                if (!master_STB) begin
                    w_ack   = 1'b0;
                    w_state = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
                w_stb   = '0;
                w_ack   = 1'b0;
            end
        endcase
    end

    assign master_DAT_O = r_dat_o;
    assign master_ACK   = r_ack;
    assign slave_STB    = r_stb;
    assign slave_WE     = r_we;
    assign slave_DAT_O  = r_wdat;
    assign slave_ADDR   = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_intercon.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bus_intercon
// Description : Self-checking bench: directed vector table, random transactions
//               against a transaction-level model, abort and async-reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_bus_intercon;

    localparam int          TO      = 8;
    localparam logic [31:0] ERR_VAL = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          master_STB = 1'b0;
    logic          master_WE = 1'b0;
    logic [31:0]   master_ADDR = '0;
    logic [31:0]   master_DAT_I = '0;
    logic [31:0]   master_DAT_O;
    logic          master_ACK;
    logic [16:0]   slave_STB;
    logic [16:0]   slave_ACK = '0;
    logic          slave_WE;
    logic [511:0]  slave_DAT_I = '0;
    logic [31:0]   slave_DAT_O;
    logic [31:0]   slave_ADDR;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_dout = '0;

    wb_bus_intercon #(
        .TIMEOUT  (TO),
        .ERR_DATA (ERR_VAL)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .master_STB   (master_STB),
        .master_WE    (master_WE),
        .master_ADDR  (master_ADDR),
        .master_DAT_I (master_DAT_I),
        .master_DAT_O (master_DAT_O),
        .master_ACK   (master_ACK),
        .slave_STB    (slave_STB),
        .slave_ACK    (slave_ACK),
        .slave_WE     (slave_WE),
        .slave_DAT_I  (slave_DAT_I),
        .slave_DAT_O  (slave_DAT_O),
        .slave_ADDR   (slave_ADDR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;     // cycles before slave ACK; -1 means never
        logic        wrong;     // other lanes ACK meanwhile
        logic [16:0] exp_stb;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // At most one strobe bit may be high at any time.
    always @(negedge clk) begin
        if (rstn) begin
            n_checks++;
            if ($countones(slave_STB) > 1) begin
                n_errors++;
                $display("FAIL onehot: got %0h expected at most one bit", slave_STB);
            end
        end
    end

    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int delay, input logic wrong,
                           input logic [16:0] exp_stb, input logic [31:0] exp_dout);
        logic [511:0] lanes;
        logic [3:0]   sel;
        int           waited;
        bit           done;
        sel = addr[31:28];
        for (int i = 0; i < 16; i++) lanes[32*i +: 32] = $urandom;
        lanes[32*sel +: 32] = rdata;

        @(negedge clk);
        master_ADDR  = addr;
        master_WE    = we;
        master_DAT_I = wdata;
        master_STB   = 1'b1;
        slave_DAT_I  = lanes;
        slave_ACK    = '0;

        @(negedge clk);
        check("strobe", slave_STB, exp_stb);
        check("slave_addr", slave_ADDR, addr);
        check("slave_we", slave_WE, we);
        check("slave_dat", slave_DAT_O, wdata);
        check("ack_idle", master_ACK, 1'b0);
        // Master-side changes during the cycle must not leak through.
        master_ADDR  = ~addr;
        master_WE    = ~we;
        master_DAT_I = ~wdata;
        if (wrong) slave_ACK = ~exp_stb;

        if (delay >= 0) begin
            repeat (delay) begin
                @(negedge clk);
                check("ack_early", master_ACK, 1'b0);
                check("strobe_hold", slave_STB, exp_stb);
            end
            slave_ACK = slave_ACK | exp_stb;
            @(negedge clk);
            check("ack", master_ACK, 1'b1);
            check("strobe_clear", slave_STB, 17'h0);
            check("dout", master_DAT_O, exp_dout);
        end else begin
            waited = 0;
            done   = 1'b0;
            while (!done && waited < TO + 4) begin
                @(negedge clk);
                waited++;
                if (master_ACK) done = 1'b1;
            end
            check("timeout_cycles", waited, TO + 1);
            check("err_strobe", slave_STB, 17'h10000);
            check("dout_timeout", master_DAT_O, exp_dout);
            @(negedge clk);
            check("err_pulse_once", slave_STB, 17'h0);
            check("ack_hold", master_ACK, 1'b1);
        end

        slave_ACK  = '0;
        master_STB = 1'b0;
        @(negedge clk);
        check("ack_drop", master_ACK, 1'b0);
        check("strobe_idle", slave_STB, 17'h0);
        check("dout_hold", master_DAT_O, exp_dout);
        check("addr_hold", slave_ADDR, addr);
        model_dout = exp_dout;
    endtask

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        logic [31:0] a, wd, rd;
        logic        we, wr;
        int          dl;

        vecs[0] = '{32'h0000_0010, 1'b0, 32'h0,         32'h1234_5678,  0, 1'b0, 17'h00001, 32'h1234_5678};
        vecs[1] = '{32'h2000_0100, 1'b1, 32'hCAFE_BABE, 32'h0,          1, 1'b0, 17'h00004, 32'h1234_5678};
        vecs[2] = '{32'h3000_0000, 1'b0, 32'h0,         32'h0000_0041,  3, 1'b1, 17'h00008, 32'h0000_0041};
        vecs[3] = '{32'h5000_0000, 1'b0, 32'h0,         32'h0,         -1, 1'b0, 17'h00020, 32'hFFFF_FFFF};
        vecs[4] = '{32'h4000_0008, 1'b0, 32'h0,         32'h0BAD_F00D,  0, 1'b0, 17'h00010, 32'h0BAD_F00D};
        vecs[5] = '{32'h1000_0004, 1'b1, 32'h55AA_55AA, 32'h0,          2, 1'b1, 17'h00002, 32'h0BAD_F00D};
        vecs[6] = '{32'hF000_0000, 1'b1, 32'h0000_1111, 32'h0,         -1, 1'b1, 17'h08000, 32'h0BAD_F00D};

        repeat (2) @(negedge clk);
        check("rst_stb", slave_STB, 17'h0);
        check("rst_ack", master_ACK, 1'b0);
        check("rst_dout", master_DAT_O, 32'h0);
        check("rst_addr", slave_ADDR, 32'h0);
        check("rst_we", slave_WE, 1'b0);
        check("rst_wdat", slave_DAT_O, 32'h0);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].rdata,
                    vecs[i].delay, vecs[i].wrong, vecs[i].exp_stb, vecs[i].exp_dout);
        end

        // Abort: STB drops while BUSY, no ACK may follow.
        @(negedge clk);
        master_ADDR = 32'h2000_0000; master_WE = 1'b0; master_STB = 1'b1;
        @(negedge clk);
        check("abort_strobe", slave_STB, 17'h00004);
        master_STB = 1'b0;
        @(negedge clk);
        check("abort_clear", slave_STB, 17'h0);
        check("abort_noack", master_ACK, 1'b0);
        slave_ACK = '1;
        @(negedge clk);
        check("abort_idle_ack", master_ACK, 1'b0);
        check("abort_dout", master_DAT_O, model_dout);
        slave_ACK = '0;

        // Randomized transactions against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            a  = $urandom;
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            rd = $urandom;
            dl = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            run_txn(a, we, wd, rd, dl, wr, 17'(1) << a[31:28],
                    we ? model_dout : ((dl < 0) ? ERR_VAL : rd));
        end

        // Asynchronous reset in the middle of BUSY.
        @(negedge clk);
        master_ADDR = 32'h4000_00F0; master_WE = 1'b1; master_DAT_I = 32'hDEAD_BEEF; master_STB = 1'b1;
        @(negedge clk);
        check("pre_rst_strobe", slave_STB, 17'h00010);
        #1 rstn = 1'b0;
        #1;
        check("arst_stb", slave_STB, 17'h0);
        check("arst_ack", master_ACK, 1'b0);
        check("arst_dout", master_DAT_O, 32'h0);
        check("arst_addr", slave_ADDR, 32'h0);
        check("arst_we", slave_WE, 1'b0);
        check("arst_wdat", slave_DAT_O, 32'h0);
        master_STB = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_dout = 32'h0;
        run_txn(32'h0000_0020, 1'b0, 32'h0, 32'h7777_0001, 0, 1'b0, 17'h00001, 32'h7777_0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
